// File: rtl/pcseq_pkg.sv
// Shared state encoding, opcode constants and decode helpers for the PC sequencer.
// Defining PCSEQ_SINGLE_STEP_EN adds the STEP_WAIT state used for single-stepping.
package pcseq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [NIBBLE_W-1:0] OP_JMP  = 4'h8;
    localparam logic [NIBBLE_W-1:0] OP_JZ   = 4'h9;
    localparam logic [NIBBLE_W-1:0] OP_JC   = 4'hA;
    localparam logic [NIBBLE_W-1:0] OP_BRA  = 4'hB;
    localparam logic [NIBBLE_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        FETCH_OP   = 4'd0,
        DECODE     = 4'd1,
        FETCH_HI   = 4'd2,
        FETCH_LO   = 4'd3,
        LOAD_HI    = 4'd4,
        LOAD_LO    = 4'd5,
        FETCH_OFF  = 4'd6,
        BRANCH_REL = 4'd7,
        EXEC       = 4'd8,
        HALT       = 4'd9
`ifdef PCSEQ_SINGLE_STEP_EN
        ,
        STEP_WAIT  = 4'd10
`endif
    } state_t;

    // Opcodes that carry a two-nibble absolute target.
    function automatic logic is_abs_jump(input logic [NIBBLE_W-1:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/pc_sequencer_chk.sv
// Property checker for the PC sequencer control outputs.
module pc_sequencer_chk (
    input logic clock,
    input logic reset,
    input logic pc_count_en,
    input logic pc_load_lo,
    input logic pc_load_hi,
    input logic pc_cy_ctrl
);

    // The PC can only do one thing per cycle: count, load low or load high.
    a_pc_ctrl_excl: assert property (@(posedge clock) disable iff (reset)
        $onehot0({pc_count_en, pc_load_lo, pc_load_hi}));

    a_cy_ctrl_with_load: assert property (@(posedge clock) disable iff (reset)
        pc_cy_ctrl |-> pc_load_lo);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/branch controller driving the 8-bit PC of the double-bus 4-bit CPU.
// Optional single-step mode is enabled with PCSEQ_SINGLE_STEP_EN.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int                  EXEC_TIMEOUT = 15,
    parameter logic [NIBBLE_W-1:0] HALT_OP      = OP_HALT
) (
    input  logic                clock,
    input  logic                reset,
`ifdef PCSEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                mem_rd,
    input  logic                mem_rdy,
    input  logic [NIBBLE_W-1:0] mem_data,
    input  logic [NIBBLE_W-1:0] pc_lo,
    input  logic                zero_flag,
    input  logic                carry_flag,
    input  logic                exec_done,
    output logic                pc_count_en,
    output logic                pc_load_lo,
    output logic                pc_load_hi,
    output logic                pc_cy_ctrl,
    output logic                pc_cy,
    output logic [NIBBLE_W-1:0] pc_nibble,
    output logic [NIBBLE_W-1:0] ir,
    output logic                exec_start,
    output logic                exec_err,
    output logic                halted
);

    localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

    // Every return to instruction fetch passes through STEP_WAIT when stepping is built in.
`ifdef PCSEQ_SINGLE_STEP_EN
    localparam state_t RESUME = STEP_WAIT;
`else
    localparam state_t RESUME = FETCH_OP;
`endif

    state_t              state_r;
    logic [NIBBLE_W-1:0] ir_r;
    logic [NIBBLE_W-1:0] temp_r;
    logic [NIBBLE_W-1:0] tlo_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                exec_err_r;

    logic [NIBBLE_W:0]   sum_s;
    logic                taken_s;
    logic                mem_rd_s;
    logic                pc_count_en_s;
    logic                pc_load_lo_s;
    logic                pc_load_hi_s;
    logic                pc_cy_ctrl_s;
    logic                pc_cy_s;
    logic [NIBBLE_W-1:0] pc_nibble_s;
    logic                exec_start_s;
    logic                halted_s;

    // PC already points past the offset nibble, so the sum is the branch target low nibble.
    assign sum_s   = {1'b0, pc_lo} + {1'b0, temp_r};
    assign taken_s = (ir_r == OP_JMP) ||
                     ((ir_r == OP_JZ) && zero_flag) ||
                     ((ir_r == OP_JC) && carry_flag);

    // Sequencer state, opcode/operand latches, exec timeout counter and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= RESUME;
            ir_r       <= 4'h0;
            temp_r     <= 4'h0;
            tlo_r      <= 4'h0;
            cnt_r      <= {CNT_W{1'b0}};
            exec_err_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH_OP: begin
                    if (mem_rdy) begin
                        ir_r    <= mem_data;
                        state_r <= DECODE;
                    end
                end
                DECODE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (is_abs_jump(ir_r))    state_r <= FETCH_HI;
                    else if (ir_r == OP_BRA)  state_r <= FETCH_OFF;
                    else if (ir_r == HALT_OP) state_r <= HALT;
                    else                      state_r <= EXEC;
                end
                FETCH_HI: begin
                    if (mem_rdy) begin
                        temp_r  <= mem_data;
                        state_r <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_rdy) begin
                        tlo_r   <= mem_data;
                        state_r <= taken_s ? LOAD_HI : RESUME;
                    end
                end
                LOAD_HI:    state_r <= LOAD_LO;
                LOAD_LO:    state_r <= RESUME;
                FETCH_OFF: begin
                    if (mem_rdy) begin
                        temp_r  <= mem_data;
                        state_r <= BRANCH_REL;
                    end
                end
                BRANCH_REL: state_r <= RESUME;
                EXEC: begin
                    // A done arriving on the final allowed cycle wins over the timeout.
                    if (exec_done) begin
                        state_r <= RESUME;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        exec_err_r <= 1'b1;
                        state_r    <= RESUME;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                HALT:       state_r <= HALT;
`ifdef PCSEQ_SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step) state_r <= FETCH_OP;
                end
`endif
                default:    state_r <= RESUME;
            endcase
        end
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        mem_rd_s      = 1'b0;
        pc_count_en_s = 1'b0;
        pc_load_lo_s  = 1'b0;
        pc_load_hi_s  = 1'b0;
        pc_cy_ctrl_s  = 1'b0;
        pc_cy_s       = 1'b0;
        pc_nibble_s   = 4'h0;
        exec_start_s  = 1'b0;
        halted_s      = 1'b0;
        if (reset) begin
            mem_rd_s = 1'b0;
        end else begin
            case (state_r)
                FETCH_OP, FETCH_HI, FETCH_LO, FETCH_OFF: begin
                    mem_rd_s      = 1'b1;
                    pc_count_en_s = mem_rdy;
                end
                DECODE: begin
                    if (!is_abs_jump(ir_r) && (ir_r != OP_BRA) && (ir_r != HALT_OP)) begin
                        exec_start_s = 1'b1;
                    end else begin
                        exec_start_s = 1'b0;
                    end
                end
                LOAD_HI: begin
                    pc_nibble_s  = temp_r;
                    pc_load_hi_s = 1'b1;
                end
                LOAD_LO: begin
                    pc_nibble_s  = tlo_r;
                    pc_load_lo_s = 1'b1;
                end
                BRANCH_REL: begin
                    pc_nibble_s  = sum_s[NIBBLE_W-1:0];
                    pc_cy_s      = sum_s[NIBBLE_W];
                    pc_cy_ctrl_s = 1'b1;
                    pc_load_lo_s = 1'b1;
                end
                HALT:       halted_s = 1'b1;
`ifdef PCSEQ_SINGLE_STEP_EN
                STEP_WAIT:  halted_s = 1'b1;
`endif
                default:    mem_rd_s = 1'b0;
            endcase
        end
    end

    assign mem_rd      = mem_rd_s;
    assign pc_count_en = pc_count_en_s;
    assign pc_load_lo  = pc_load_lo_s;
    assign pc_load_hi  = pc_load_hi_s;
    assign pc_cy_ctrl  = pc_cy_ctrl_s;
    assign pc_cy       = pc_cy_s;
    assign pc_nibble   = pc_nibble_s;
    assign ir          = ir_r;
    assign exec_start  = exec_start_s;
    assign exec_err    = exec_err_r;
    assign halted      = halted_s;

    pc_sequencer_chk u_chk (
        .clock       (clock),
        .reset       (reset),
        .pc_count_en (pc_count_en),
        .pc_load_lo  (pc_load_lo),
        .pc_load_hi  (pc_load_hi),
        .pc_cy_ctrl  (pc_cy_ctrl)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Cycle-accurate scoreboard bench for pc_sequencer: per-cycle stimulus rows with expected outputs.
module tb_pc_sequencer;

    // {rst, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done}
    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [3:0] data;
        logic [3:0] plo;
        logic       zf;
        logic       cf;
        logic       done;
    } in_t;

    typedef struct packed {
        logic       mem_rd;
        logic       cen;
        logic       llo;
        logic       lhi;
        logic       cyc;
        logic       cy;
        logic [3:0] nib;
        logic       es;
        logic       ee;
        logic       h;
        logic [3:0] ir;
    } out_t;

    logic       clock;
    logic       reset;
    logic       mem_rd;
    logic       mem_rdy;
    logic [3:0] mem_data;
    logic [3:0] pc_lo;
    logic       zero_flag;
    logic       carry_flag;
    logic       exec_done;
    logic       pc_count_en;
    logic       pc_load_lo;
    logic       pc_load_hi;
    logic       pc_cy_ctrl;
    logic       pc_cy;
    logic [3:0] pc_nibble;
    logic [3:0] ir;
    logic       exec_start;
    logic       exec_err;
    logic       halted;
`ifdef PCSEQ_SINGLE_STEP_EN
    logic       step;
    assign step = 1'b1;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t exp_q[$];
    logic [3:0] exp_ir  = 4'h0;
    logic       exp_err = 1'b0;

    pc_sequencer dut (
        .clock       (clock),
        .reset       (reset),
`ifdef PCSEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .mem_rd      (mem_rd),
        .mem_rdy     (mem_rdy),
        .mem_data    (mem_data),
        .pc_lo       (pc_lo),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .exec_done   (exec_done),
        .pc_count_en (pc_count_en),
        .pc_load_lo  (pc_load_lo),
        .pc_load_hi  (pc_load_hi),
        .pc_cy_ctrl  (pc_cy_ctrl),
        .pc_cy       (pc_cy),
        .pc_nibble   (pc_nibble),
        .ir          (ir),
        .exec_start  (exec_start),
        .exec_err    (exec_err),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic in_t si(input logic rst, input logic rdy, input logic [3:0] data,
                               input logic [3:0] plo, input logic zf, input logic cf,
                               input logic done);
        return {rst, rdy, data, plo, zf, cf, done};
    endfunction

    function automatic out_t w(input logic mrd, input logic cen, input logic llo,
                               input logic lhi, input logic cyc, input logic cy,
                               input logic [3:0] nib, input logic es, input logic h);
        return {mrd, cen, llo, lhi, cyc, cy, nib, es, exp_err, h, exp_ir};
    endfunction

    function automatic out_t w_idle();
        return w(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endfunction

    function automatic out_t w_rdy();
        return w(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endfunction

    function automatic out_t w_none();
        return w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endfunction

    function automatic in_t s_quiet();
        return si(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic in_t s_mem(input logic [3:0] data);
        return si(1'b0, 1'b1, data, 4'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic out_t sample();
        return {mem_rd, pc_count_en, pc_load_lo, pc_load_hi, pc_cy_ctrl, pc_cy,
                pc_nibble, exec_start, exec_err, halted, ir};
    endfunction

`ifdef PCSEQ_SINGLE_STEP_EN
`define PCSEQ_TB_STEP_ROW begin st.push_back(s_quiet()); wt.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1)); end
`else
`define PCSEQ_TB_STEP_ROW begin end
`endif

    task automatic test_reset();
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        exp_ir  = 4'h0;
        exp_err = 1'b0;
        st.push_back(si(1'b1, 1'b1, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1)); wt.push_back(w_none());
        `PCSEQ_TB_STEP_ROW
        st.push_back(s_quiet()); wt.push_back(w_idle());
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset row %0d: got %h, want %h", i, got, exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_jump(input logic [3:0] op, input logic [3:0] hi, input logic [3:0] lo,
                             input logic zf, input logic cf, input logic taken);
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        st.push_back(s_mem(op)); wt.push_back(w_rdy());
        exp_ir = op;
        st.push_back(s_quiet()); wt.push_back(w_none());
        st.push_back(s_mem(hi)); wt.push_back(w_rdy());
        st.push_back(si(1'b0, 1'b1, lo, 4'h0, zf, cf, 1'b0)); wt.push_back(w_rdy());
        if (taken) begin
            st.push_back(s_quiet());
            wt.push_back(w(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hi, 1'b0, 1'b0));
            st.push_back(s_quiet());
            wt.push_back(w(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lo, 1'b0, 1'b0));
        end
        `PCSEQ_TB_STEP_ROW
        st.push_back(s_quiet()); wt.push_back(w_idle());
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL jump op=%h row %0d: got %h, want %h", op, i, got, exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_bra(input logic [3:0] off, input logic [3:0] plo,
                            input logic [3:0] nib, input logic cy);
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        st.push_back(s_mem(4'hB)); wt.push_back(w_rdy());
        exp_ir = 4'hB;
        st.push_back(s_quiet()); wt.push_back(w_none());
        st.push_back(s_mem(off)); wt.push_back(w_rdy());
        st.push_back(si(1'b0, 1'b0, 4'h0, plo, 1'b0, 1'b0, 1'b0));
        wt.push_back(w(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cy, nib, 1'b0, 1'b0));
        `PCSEQ_TB_STEP_ROW
        st.push_back(s_quiet()); wt.push_back(w_idle());
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bra off=%h row %0d: got %h, want %h", off, i, got, exp);
            end
            @(posedge clock); #1;
        end
    endtask

    // done_at = EXEC cycle (1-based) carrying exec_done; 0 means the datapath never answers.
    task automatic test_exec(input int done_at);
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        int   n_exec;
        n_exec = (done_at == 0) ? 15 : done_at;
        st.push_back(s_mem(4'h2)); wt.push_back(w_rdy());
        exp_ir = 4'h2;
        st.push_back(s_quiet());
        wt.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0));
        for (int k = 1; k <= n_exec; k++) begin
            st.push_back(si(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, (k == done_at)));
            wt.push_back(w_none());
        end
        if (done_at == 0) exp_err = 1'b1;
        `PCSEQ_TB_STEP_ROW
        st.push_back(s_quiet()); wt.push_back(w_idle());
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL exec done_at=%0d row %0d: got %h, want %h", done_at, i, got, exp);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid();
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        st.push_back(s_mem(4'h8)); wt.push_back(w_rdy());
        exp_ir = 4'h8;
        st.push_back(s_quiet()); wt.push_back(w_none());
        st.push_back(s_quiet()); wt.push_back(w_idle());
        // Reset in the second wait cycle, with a late mem_rdy that must be ignored.
        st.push_back(si(1'b1, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b1)); wt.push_back(w_none());
        exp_ir  = 4'h0;
        exp_err = 1'b0;
        `PCSEQ_TB_STEP_ROW
        st.push_back(s_quiet()); wt.push_back(w_idle());
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid row %0d: got %h, want %h", i, got, exp);
            end
            @(posedge clock); #1;
        end
        n_tests++;
        if (dut.temp_r !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid temp: got %h, want 0", dut.temp_r);
        end
    endtask

    task automatic test_halt();
        in_t  st[$];
        out_t wt[$];
        out_t got;
        out_t exp;
        st.push_back(s_mem(4'hF)); wt.push_back(w_rdy());
        exp_ir = 4'hF;
        st.push_back(s_quiet()); wt.push_back(w_none());
        for (int k = 0; k < 20; k++) begin
            st.push_back(si(1'b0, 1'b1, 4'h8, 4'h3, 1'b1, 1'b1, 1'b1));
            wt.push_back(w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1));
        end
        for (int i = 0; i < st.size(); i++) begin
            {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} = st[i];
            exp_q.push_back(wt[i]);
            @(negedge clock);
            got = sample();
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL halt row %0d: got %h, want %h", i, got, exp);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {reset, mem_rdy, mem_data, pc_lo, zero_flag, carry_flag, exec_done} =
            si(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        test_reset();
        test_jump(4'h8, 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
        test_jump(4'h9, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0);
        test_jump(4'hA, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1);
        test_jump(4'h9, 4'hF, 4'hE, 1'b1, 1'b0, 1'b1);
        test_jump(4'hA, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0);
        test_bra(4'h9, 4'hA, 4'h3, 1'b1);
        test_bra(4'h2, 4'h4, 4'h6, 1'b0);
        test_bra(4'hF, 4'h1, 4'h0, 1'b1);
        test_exec(3);
        test_exec(15);
        test_exec(0);
        test_reset_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/branch controller for the 8-bit program counter of the double-bus 4-bit processor.
- Drives the PC's control inputs: low-nibble load, high-nibble load, count enable, carry control, carry in and 4-bit parallel input.
- Runs the nibble-wide program-memory handshake and latches the opcode nibble.
- Hands non-control-flow opcodes to the ALU/register datapath through a start/done handshake.

Parameters:
- EXEC_TIMEOUT, 15: max cycles to wait for exec_done before flagging exec_err and moving on.
- HALT_OP, 4'hF: opcode that parks the sequencer.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_rd  out  1  program-memory read request
- mem_rdy  in  1  memory data valid this cycle
- mem_data  in  4  fetched nibble
- pc_lo  in  4  current PC Q[3:0], used for relative branch
- zero_flag  in  1  ALU zero flag
- carry_flag  in  1  ALU carry flag
- exec_done  in  1  datapath finished current opcode
- pc_count_en  out  1  PC increment
- pc_load_lo  out  1  PC low-nibble load (enable1)
- pc_load_hi  out  1  PC high-nibble load (enable2)
- pc_cy_ctrl  out  1  enables carry into PC high nibble on a low load
- pc_cy  out  1  carry value into PC
- pc_nibble  out  4  PC parallel input
- ir  out  4  latched opcode
- exec_start  out  1  one-cycle pulse starting the datapath
- exec_err  out  1  sticky timeout flag
- halted  out  1  sequencer parked in HALT

Behaviour:
- Reset (synchronous, highest priority): state FETCH_OP. ir=0, temp=0, exec_err=0. All outputs 0.
- Reset mid-operation: any in-flight mem_rdy or exec_done is ignored.
- Opcodes:
  - 0x8 JMP abs: two operand nibbles, high then low.
  - 0x9 JZ abs and 0xA JC abs: same operands as JMP, taken if the flag is 1.
  - 0xB BRA rel: one unsigned offset nibble, forward branch.
  - HALT_OP: park.
  - All other opcodes: EXEC.
- Fetch rule, every fetch state:
  - mem_rd=1 until mem_rdy.
  - In the mem_rdy cycle, pc_count_en=1 combinationally and the nibble is captured.
  - Zero wait states: 1 cycle per nibble.
- PC control exclusivity: at most one of pc_count_en, pc_load_lo and pc_load_hi is high in any cycle. Assertion required.
- FETCH_OP: on mem_rdy, ir<=mem_data, go to DECODE.
- DECODE (1 cycle):
  - 8/9/A go to FETCH_HI.
  - B goes to FETCH_OFF.
  - HALT_OP goes to HALT.
  - Otherwise pulse exec_start and go to EXEC.
- FETCH_HI: on mem_rdy, temp<=mem_data, go to FETCH_LO.
- FETCH_LO: on mem_rdy, tlo<=mem_data, then:
  - If JMP, or JZ with zero_flag=1, or JC with carry_flag=1: go to LOAD_HI.
  - Otherwise go to FETCH_OP. Not taken; the PC is already past the operands.
  - Flags are sampled in this cycle.
- LOAD_HI: pc_nibble=temp, pc_load_hi=1, go to LOAD_LO.
- LOAD_LO: pc_nibble=tlo, pc_load_lo=1, pc_cy_ctrl=0, go to FETCH_OP.
- FETCH_OFF: on mem_rdy, temp<=mem_data, go to BRANCH_REL.
- BRANCH_REL:
  - sum = {1'b0,pc_lo} + {1'b0,temp} (5-bit).
  - Drive pc_nibble=sum[3:0], pc_cy=sum[4], pc_cy_ctrl=1, pc_load_lo=1. Go to FETCH_OP.
  - The offset is relative to the address after the offset nibble. Wrap 0xFF→0x00 is inherent in the PC.
- EXEC: wait for exec_done, then go to FETCH_OP.
  - Counter reaching EXEC_TIMEOUT sets exec_err=1 and goes to FETCH_OP.
  - exec_done in the same cycle as the timeout counts as done.
- HALT: halted=1, all PC controls 0, stays until reset.
- Total cycles: JMP taken = 6, not taken = 4, BRA = 4, EXEC = 3 + datapath.

Optional Feature:
- Macro: PCSEQ_SINGLE_STEP_EN.
- With the macro:
  - Adds input step (1 bit).
  - Every transition into FETCH_OP first enters a STEP_WAIT state. STEP_WAIT has halted=1 and outputs idle.
  - STEP_WAIT leaves on step=1.
  - Reset enters STEP_WAIT.
- Without the macro: no step port and no STEP_WAIT state.

Decomposition:
- Package pcseq_pkg:
  - State enum.
  - Opcode localparams OP_JMP, OP_JZ, OP_JC, OP_BRA, OP_HALT.
  - Nibble width constant.
- Sub-module: none. Single FSM plus a 5-bit adder; the timeout counter is inline.

Test Plan:
- Reset, then mem returns 0x8,0x3,0xC with mem_rdy=1 → pc_count_en 3 cycles, then pc_load_hi with nibble 3, then pc_load_lo with nibble C. 6 cycles total.
- JZ 0x9,0x5,0x0 with zero_flag=0 → no loads; FETCH_OP after 4 cycles; 3 increments total.
- BRA 0xB,0x9 with pc_lo=0xA → pc_nibble=0x3, pc_cy=1, pc_cy_ctrl=1, pc_load_lo=1 in one cycle.
- Opcode 0x2 with exec_done never asserted → exec_start single pulse; exec_err=1 after 15 EXEC cycles; fetch resumes.
- mem_rdy delayed 3 cycles during FETCH_HI, with reset pulsed in the 2nd wait cycle → next cycle all outputs 0, state FETCH_OP, temp unchanged at 0.
- Opcode 0xF → halted=1 permanently, no PC control activity for 20 cycles. With PCSEQ_SINGLE_STEP_EN, one step pulse is needed per instruction.
